// File: rtl/ads1292_frame_packer.sv
`default_nettype none
// ads1292_frame_packer: splits ADS1292 RDATAC frames into two checksummed 40-bit
// channel packets and queues them in a small FIFO for the UART transmitter.
module ads1292_frame_packer #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] HDR_NIBBLE = 4'hC
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [71:0]                 i_FRAME,
  input  logic                        i_FRAME_VALID,
  input  logic                        i_ENABLE,
  input  logic                        i_CLR_ERR,
  output logic [39:0]                 o_PKT,
  output logic                        o_PKT_VALID,
  input  logic                        i_PKT_READY,
  output logic                        o_HDR_ERR,
  output logic                        o_OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0] o_LEVEL
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] SPACE_LIMIT = LW'(FIFO_DEPTH - 2);

  generate
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PUSH_CH1 = 2'd1,
    PUSH_CH2 = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [23:0]   ch1_hold;
  logic [23:0]   ch2_hold;
  logic [2:0]    seq;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [39:0]   mem [FIFO_DEPTH];
  logic          hdr_err;
  logic          overflow;

  logic          frame_seen;
  logic          hdr_ok;
  logic          has_space;
  logic          accept;
  logic          hdr_drop;
  logic          ovf_drop;
  logic          push;
  logic          pop;
  logic          push_ch;
  logic [23:0]   push_sample;
  logic [7:0]    pkt_top;
  logic [39:0]   push_pkt;
  logic          unused_status;

  // Status bits below the header nibble carry no information for the packer.
  assign unused_status = ^i_FRAME[67:48];

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = PUSH_CH1;
      PUSH_CH1: state_nxt = PUSH_CH2;
      PUSH_CH2: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame qualification; header errors take priority over busy/space drops.
  always_comb begin
    frame_seen = i_FRAME_VALID && i_ENABLE;
    hdr_ok     = (i_FRAME[71:68] == HDR_NIBBLE);
    has_space  = (level <= SPACE_LIMIT);
    hdr_drop   = frame_seen && !hdr_ok;
    ovf_drop   = frame_seen && hdr_ok && ((state != IDLE) || !has_space);
    accept     = frame_seen && hdr_ok && (state == IDLE) && has_space;
  end

  // Packet assembly for the channel being written this cycle.
  always_comb begin
    push        = (state == PUSH_CH1) || (state == PUSH_CH2);
    push_ch     = (state == PUSH_CH2);
    push_sample = push_ch ? ch2_hold : ch1_hold;
    pkt_top     = {4'hA, push_ch, seq};
    push_pkt    = {pkt_top, push_sample,
                   pkt_top ^ push_sample[23:16] ^ push_sample[15:8] ^ push_sample[7:0]};
    pop         = (level != '0) && i_PKT_READY;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ch1_hold <= '0;
      ch2_hold <= '0;
    end else if (accept) begin
      ch1_hold <= i_FRAME[47:24];
      ch2_hold <= i_FRAME[23:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seq <= '0;
    end else if (state == PUSH_CH2) begin
      seq <= seq + 3'd1;
    end
  end

  // Storage needs no reset: the read side is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_pkt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A new error in the same cycle as a clear request wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hdr_err  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (hdr_drop)       hdr_err <= 1'b1;
      else if (i_CLR_ERR) hdr_err <= 1'b0;
      if (ovf_drop)       overflow <= 1'b1;
      else if (i_CLR_ERR) overflow <= 1'b0;
    end
  end

  assign o_PKT_VALID = (level != '0);
  assign o_PKT       = o_PKT_VALID ? mem[rd_ptr] : '0;
  assign o_LEVEL     = level;
  assign o_HDR_ERR   = hdr_err;
  assign o_OVERFLOW  = overflow;

endmodule
`default_nettype wire

// File: tb/tb_ads1292_frame_packer.sv
`default_nettype none
// tb_ads1292_frame_packer: directed and randomized frames checked cycle by cycle
// against a queue-based model of the packet stream.
module tb_ads1292_frame_packer;

  localparam int         DEPTH = 8;
  localparam logic [3:0] HDR   = 4'hC;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [71:0] frame = '0;
  logic        frame_valid = 1'b0;
  logic        enable = 1'b1;
  logic        clr_err = 1'b0;
  logic [39:0] pkt;
  logic        pkt_valid;
  logic        pkt_ready = 1'b1;
  logic        hdr_err;
  logic        overflow;
  logic [3:0]  level;

  ads1292_frame_packer #(.FIFO_DEPTH(DEPTH), .HDR_NIBBLE(HDR)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_FRAME      (frame),
    .i_FRAME_VALID(frame_valid),
    .i_ENABLE     (enable),
    .i_CLR_ERR    (clr_err),
    .o_PKT        (pkt),
    .o_PKT_VALID  (pkt_valid),
    .i_PKT_READY  (pkt_ready),
    .o_HDR_ERR    (hdr_err),
    .o_OVERFLOW   (overflow),
    .o_LEVEL      (level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: packets visible in the FIFO, packets still to be written,
  // an unbounded frame counter and the two sticky flags.
  logic [39:0] m_fifo[$];
  logic [39:0] m_pend[$];
  int          m_seq = 0;
  bit          m_hdr = 0;
  bit          m_ovf = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [39:0] mk_pkt(input bit ch, input int seqn, input logic [23:0] s);
    logic [7:0] b4;
    b4 = {4'hA, ch, 3'(seqn % 8)};
    return {b4, s, b4 ^ s[23:16] ^ s[15:8] ^ s[7:0]};
  endfunction

  function automatic logic [71:0] rnd_frame(input bit good);
    logic [3:0] h;
    h = good ? HDR : 4'($urandom_range(0, 15));
    return {h, 20'($urandom), 24'($urandom), 24'($urandom)};
  endfunction

  task automatic check_outputs();
    chk("valid", 64'(pkt_valid), 64'(m_fifo.size() != 0));
    chk("level", 64'(level), 64'(m_fifo.size()));
    chk("hdr_err", 64'(hdr_err), 64'(m_hdr));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (m_fifo.size() != 0) chk("pkt", 64'(pkt), 64'(m_fifo[0]));
  endtask

  // One clock: model update from pre-edge state, edge, then compare.
  task automatic tick(input bit v, input logic [71:0] f);
    bit do_pop, busy, nh, no, acc;
    frame       = f;
    frame_valid = v;
    do_pop = (m_fifo.size() != 0) && pkt_ready;
    busy   = (m_pend.size() != 0);
    nh = clr_err ? 1'b0 : m_hdr;
    no = clr_err ? 1'b0 : m_ovf;
    acc = 0;
    if (v && enable) begin
      if (f[71:68] != HDR) nh = 1;
      else if (busy || m_fifo.size() > DEPTH - 2) no = 1;
      else acc = 1;
    end
    if (do_pop) void'(m_fifo.pop_front());
    if (busy) m_fifo.push_back(m_pend.pop_front());
    if (acc) begin
      m_pend.push_back(mk_pkt(1'b0, m_seq, f[47:24]));
      m_pend.push_back(mk_pkt(1'b1, m_seq, f[23:0]));
      m_seq++;
    end
    m_hdr = nh;
    m_ovf = no;
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0);
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_pend.delete();
    m_seq = 0;
    m_hdr = 0;
    m_ovf = 0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_valid", 64'(pkt_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_pkt", 64'(pkt), 64'd0);
    chk("rst_flags", 64'({hdr_err, overflow}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Reference frame: known packet values and latency
    tick(1'b1, 72'hC00000_123456_FEDCBA);
    chk("lat_e0", 64'(pkt_valid), 64'd0);
    tick(1'b0, '0);
    chk("ref_ch1", 64'(pkt), 64'hA0123456D0);
    tick(1'b0, '0);
    chk("ref_ch2", 64'(pkt), 64'hA8FEDCBA30);
    idle(2);

    // Bad header, then clear
    tick(1'b1, {4'h8, 68'h0000_111111_222222});
    idle(1);
    chk("hdr_set", 64'(hdr_err), 64'd1);
    clr_err = 1'b1;
    tick(1'b0, '0);
    clr_err = 1'b0;
    chk("hdr_clr", 64'(hdr_err), 64'd0);

    // Fill with consumer stalled, overflow on the fifth frame, then drain
    pkt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, rnd_frame(1'b1));
      idle(2);
    end
    chk("full_level", 64'(level), 64'd8);
    tick(1'b1, rnd_frame(1'b1));
    chk("full_ovf", 64'(overflow), 64'd1);
    pkt_ready = 1'b1;
    idle(10);
    clr_err = 1'b1;
    tick(1'b0, '0);
    clr_err = 1'b0;

    // Back-to-back frame while busy
    tick(1'b1, rnd_frame(1'b1));
    tick(1'b1, rnd_frame(1'b1));
    chk("busy_ovf", 64'(overflow), 64'd1);
    idle(4);

    // Nine frames streamed with a mid-stream stall (sequence wraps)
    for (int i = 0; i < 9; i++) begin
      pkt_ready = (i == 4) ? 1'b0 : 1'b1;
      tick(1'b1, rnd_frame(1'b1));
      idle(2);
    end
    pkt_ready = 1'b1;
    idle(6);

    // Reset during PUSH_CH2
    tick(1'b1, rnd_frame(1'b1));
    tick(1'b0, '0);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_valid", 64'(pkt_valid), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick(1'b1, 72'hC00000_000001_000002);
    tick(1'b0, '0);
    chk("post_rst_seq", 64'(pkt[34:32]), 64'd0);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      pkt_ready = ($urandom_range(0, 9) < 6);
      clr_err   = ($urandom_range(0, 19) == 0);
      tick($urandom_range(0, 2) == 0, rnd_frame($urandom_range(0, 4) != 0));
    end
    clr_err   = 1'b0;
    enable    = 1'b1;
    pkt_ready = 1'b1;
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ads1292_frame_packer.md
ADS1292_FRAME_PACKER -- requirements
Module: ads1292_frame_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, packet FIFO entries; power of two, minimum 4.
REQ-002 Parameter HDR_NIBBLE, default 4'hC, required value of status word bits [71:68].
REQ-003 clk  input  1  single clock for all state; the block shall use one clock only.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 i_FRAME  input  72  RDATAC frame: [71:48] status, [47:24] CH1, [23:0] CH2.
REQ-006 i_FRAME_VALID  input  1  one-cycle strobe; i_FRAME is valid in the same cycle.
REQ-007 i_ENABLE  input  1  frame acceptance enable.
REQ-008 i_CLR_ERR  input  1  clears sticky error flags.
REQ-009 o_PKT  output  40  FIFO head packet for uart_controller TX.
REQ-010 o_PKT_VALID  output  1  FIFO non-empty.
REQ-011 i_PKT_READY  input  1  consumer accepts the head packet.
REQ-012 o_HDR_ERR  output  1  sticky; a frame was dropped for a bad header.
REQ-013 o_OVERFLOW  output  1  sticky; a frame was dropped for busy or insufficient space.
REQ-014 o_LEVEL  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 FSM states: IDLE, PUSH_CH1, PUSH_CH2. Transitions: IDLE->PUSH_CH1 on frame accept; PUSH_CH1->PUSH_CH2 unconditionally; PUSH_CH2->IDLE unconditionally.
REQ-016 Frame accept condition: state==IDLE, i_FRAME_VALID=1, i_ENABLE=1, i_FRAME[71:68]==HDR_NIBBLE, o_LEVEL<=FIFO_DEPTH-2. On accept, CH1 and CH2 are captured into holding registers.
REQ-017 Drop rules when i_FRAME_VALID=1 and i_ENABLE=1:
  - bad header: drop the frame and set o_HDR_ERR; this rule takes priority.
  - otherwise, state!=IDLE or o_LEVEL>FIFO_DEPTH-2: drop the frame and set o_OVERFLOW.
  - A dropped frame produces no partial push.
REQ-018 When i_ENABLE=0, frames are ignored silently, with no flag change; the FIFO continues to drain.
REQ-019 Packet format:
  - [39:36]=4'hA
  - [35]=channel (0 CH1, 1 CH2)
  - [34:32]=frame sequence number
  - [31:8]=24-bit sample, unmodified two's complement
  - [7:0]=XOR of bytes [39:32], [31:24], [23:16], [15:8]
REQ-020 PUSH_CH1 writes the CH1 packet and PUSH_CH2 writes the CH2 packet, one write per cycle; both packets carry the same sequence number.
REQ-021 The 3-bit sequence counter increments once per accepted frame, after the PUSH_CH2 write; it wraps 7->0; dropped frames do not increment it.
REQ-022 Latency: for a frame sampled on edge E, the CH1 packet is written on E+1 and the CH2 packet on E+2. With an empty FIFO, o_PKT_VALID=1 after E+1.
REQ-023 Output handshake:
  - A pop occurs when o_PKT_VALID & i_PKT_READY on a rising edge.
  - o_PKT shall hold stable while o_PKT_VALID=1 and no pop occurs.
  - o_PKT is don't-care while o_PKT_VALID=0.
REQ-024 A simultaneous push and pop leaves o_LEVEL unchanged. Read and write pointers wrap modulo FIFO_DEPTH. A pop on empty is impossible because o_PKT_VALID gates it.
REQ-025 The space check at accept guarantees no write into a full FIFO; no FIFO overwrite shall ever occur.
REQ-026 i_CLR_ERR=1 clears both sticky flags on the next edge. If a new error occurs in the same cycle, the error wins and its flag reads 1.

Reset
REQ-027 While rstn=0, asynchronously:
  - state=IDLE, FIFO pointers and level=0, sequence=0, holding registers=0
  - o_PKT_VALID=0, o_LEVEL=0, o_HDR_ERR=0, o_OVERFLOW=0, o_PKT=0
REQ-028 Reset asserted mid-PUSH_CH1/CH2 discards the in-flight frame and all FIFO contents. After release, the first accepted frame uses sequence 0.

Verification
REQ-029 Frame 0xC00000_123456_FEDCBA, i_ENABLE=1, i_PKT_READY=1 -> o_PKT=0xA0123456D0, then 0xA8FEDCBA30; o_PKT_VALID first high after E+1.
REQ-030 Frame with status 0x800000 -> no packets, o_HDR_ERR=1, sequence unchanged; then i_CLR_ERR pulse -> o_HDR_ERR=0.
REQ-031 i_PKT_READY=0, four good frames with FIFO_DEPTH=8 -> o_LEVEL=8; fifth frame dropped, o_OVERFLOW=1; draining yields 8 packets in order with seq 0,0,1,1,2,2,3,3.
REQ-032 Second i_FRAME_VALID one cycle after an accepted frame -> second frame dropped, o_OVERFLOW=1, only 2 packets produced.
REQ-033 Nine good frames streamed -> the ninth frame's packets carry seq 0 (wrap). Holding i_PKT_READY=0 for 3 cycles mid-stream -> o_PKT stable, no loss.
REQ-034 rstn pulsed low during PUSH_CH2 -> immediately o_PKT_VALID=0 and o_LEVEL=0; the next good frame is emitted with seq 0.
